// File: rtl/kersram_wr_multi.sv
// kersram_wr_multi: kernel-SRAM write engine draining a FWFT kernel FIFO into NUM_BANK SRAM banks
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, abort          job launch (IDLE only) and synchronous cancel (wins over everything)
//   cfg_len               words per bank (0 = no-op)
//   cfg_bank_num          active banks (0 = no-op, clamped to NUM_BANK)
//   cfg_base_addr         first SRAM address in every bank
//   cfg_mode              0 = sequential bank fill, 1 = broadcast to all active banks
//   fifo_dout/empty_n     FIFO head word and valid
//   fifo_read             pop strobe, combinational, LOAD only
//   cen/wen/addr/din      registered per-bank SRAM write port (active-low enables)
//   busy, done            job in progress, one-cycle completion pulse
//   bank_idx              bank being filled in sequential mode
//   words_written         FIFO words accepted in the current job
module kersram_wr_multi #(
    parameter int NUM_BANK = 8,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 10,
    localparam int BI_W    = $clog2(NUM_BANK),
    localparam int BN_W    = BI_W + 1,
    localparam int WW_W    = ADDR_W + BI_W + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ADDR_W-1:0]          cfg_len,
    input  logic [BN_W-1:0]            cfg_bank_num,
    input  logic [ADDR_W-1:0]          cfg_base_addr,
    input  logic                       cfg_mode,
    input  logic [DATA_W-1:0]          fifo_dout,
    input  logic                       fifo_empty_n,
    output logic                       fifo_read,
    output logic [NUM_BANK-1:0]        cen,
    output logic [NUM_BANK-1:0]        wen,
    output logic [NUM_BANK*ADDR_W-1:0] addr,
    output logic [NUM_BANK*DATA_W-1:0] din,
    output logic                       busy,
    output logic                       done,
    output logic [BI_W-1:0]            bank_idx,
    output logic [WW_W-1:0]            words_written
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] len_q, base_q, wcnt;
    logic [BN_W-1:0]   banks_q;
    logic              mode_q, accept, wcnt_last, last, noop;
    assign fifo_read = (state == LOAD) && fifo_empty_n;
    // a word popped in the abort cycle is consumed but never written
    assign accept    = fifo_read && !abort;
    assign wcnt_last = wcnt == len_q - ADDR_W'(1);
    assign last      = wcnt_last && (mode_q || {1'b0, bank_idx} == banks_q - BN_W'(1));
    assign noop      = cfg_len == '0 || cfg_bank_num == '0;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign wen       = cen;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (abort)                state_n = IDLE;
        else if (state == IDLE)   state_n = start ? (noop ? DONE : LOAD) : IDLE;
        else if (state == LOAD)   state_n = (accept && last) ? FLUSH : LOAD;
        else                      state_n = (state == FLUSH) ? DONE : IDLE;
    end
    // write port defaults to idle every cycle, so a write lasts exactly one cycle
    // and banks not written in a cycle present address/data 0
    always_ff @(posedge clk) begin
        if (reset) begin
            cen           <= '1;
            addr          <= '0;
            din           <= '0;
            wcnt          <= '0;
            bank_idx      <= '0;
            words_written <= '0;
            len_q         <= '0;
            base_q        <= '0;
            banks_q       <= '0;
            mode_q        <= 1'b0;
        end else begin
            cen  <= '1;
            addr <= '0;
            din  <= '0;
            if (abort) begin
                wcnt          <= '0;
                bank_idx      <= '0;
                words_written <= '0;
            end else if (state == IDLE && start) begin
                len_q         <= cfg_len;
                base_q        <= cfg_base_addr;
                mode_q        <= cfg_mode;
                banks_q       <= cfg_bank_num > BN_W'(NUM_BANK) ? BN_W'(NUM_BANK) : cfg_bank_num;
                wcnt          <= '0;
                bank_idx      <= '0;
                words_written <= '0;
            end else if (accept) begin
                words_written <= words_written + WW_W'(1);
                wcnt          <= wcnt_last ? '0 : wcnt + ADDR_W'(1);
                bank_idx      <= (last || mode_q) ? '0 : bank_idx + BI_W'(wcnt_last);
                for (int b = 0; b < NUM_BANK; b++) begin
                    if (BN_W'(b) < banks_q && (mode_q || BI_W'(b) == bank_idx)) begin
                        cen[b]                   <= 1'b0;
                        addr[b*ADDR_W +: ADDR_W] <= base_q + wcnt;
                        din[b*DATA_W +: DATA_W]  <= fifo_dout;
                    end
                end
            end
        end
    end
endmodule

// File: doc/kersram_wr_multi.md
Name: kersram_wr_multi

Overview:
Parametrised kernel-SRAM write engine. Drains a FIFO-style kernel stream into NUM_BANK single-port kernel SRAM banks. Supports a runtime-selectable sequential fill (bank by bank) or broadcast (same word to all active banks), plus a programmable bank count, base address and abort. Sits between the kernel input FIFO and the kernel SRAM array and is launched by the layer controller once per layer.

Parameters:
NUM_BANK, 8, number of kernel SRAM banks (2..16)
DATA_W, 64, FIFO and SRAM data width
ADDR_W, 10, SRAM address width; also the width of cfg_len

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  launch pulse; sampled only in IDLE
abort  in  1  synchronous cancel; wins over every other event
cfg_len  in  ADDR_W  words per bank; 0 means no-op
cfg_bank_num  in  $clog2(NUM_BANK)+1  active banks; 0 means no-op; values above NUM_BANK are clamped to NUM_BANK
cfg_base_addr  in  ADDR_W  first SRAM address written in each bank
cfg_mode  in  1  0 = sequential, 1 = broadcast
fifo_dout  in  DATA_W  FIFO head word (first-word-fall-through)
fifo_empty_n  in  1  FIFO holds a valid word
fifo_read  out  1  pop strobe; a word transfers when fifo_read & fifo_empty_n
cen  out  NUM_BANK  per-bank chip enable, active low, registered
wen  out  NUM_BANK  per-bank write enable, active low; equal to cen
addr  out  NUM_BANK*ADDR_W  flat per-bank address; bank b uses [b*ADDR_W +: ADDR_W]; registered
din  out  NUM_BANK*DATA_W  flat per-bank write data; registered
busy  out  1  high in LOAD, FLUSH and DONE
done  out  1  one-cycle completion pulse
bank_idx  out  $clog2(NUM_BANK)  bank currently being filled (sequential mode); 0 otherwise
words_written  out  ADDR_W+$clog2(NUM_BANK)+1  count of FIFO words accepted in the current job

Behaviour:
- Reset values: cen and wen all 1, addr 0, din 0, fifo_read 0, busy 0, done 0, bank_idx 0, words_written 0; FSM in IDLE.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE -> LOAD on start when latched cfg_len != 0 and cfg_bank_num != 0.
- IDLE -> DONE on start when cfg_len == 0 or cfg_bank_num == 0. Nothing is read from the FIFO.
- LOAD -> FLUSH on the accept of the final word.
- FLUSH -> DONE after 1 cycle; the final SRAM write is presented during FLUSH.
- DONE -> IDLE after 1 cycle; done = 1 only while in DONE.
- All cfg_* inputs are latched on start. Changes to them mid-job are ignored.
- start is ignored outside IDLE.
- fifo_read = (state == LOAD) & fifo_empty_n. It is combinational and never asserts outside LOAD.
- Word counter wcnt runs 0..cfg_len-1 and advances on each accept.
- Sequential mode:
  - The accepted word goes to bank bank_idx at address (cfg_base_addr + wcnt) mod 2^ADDR_W.
  - When wcnt == cfg_len-1 it wraps to 0 and bank_idx increments.
  - The final word is wcnt == cfg_len-1 with bank_idx == cfg_bank_num-1.
  - Total words = cfg_len * cfg_bank_num.
- Broadcast mode:
  - Each accepted word is written to every bank b < cfg_bank_num at the same address in the same cycle.
  - bank_idx stays 0. The final word is wcnt == cfg_len-1. Total words = cfg_len.
- Write latency: exactly 1 cycle. An accept in cycle N produces cen[b] = wen[b] = 0 with the matching addr/din in cycle N+1. cen returns to 1 in any cycle after a non-accept.
- Banks at or above cfg_bank_num keep cen = 1. Their addr and din are 0.
- Address arithmetic is modulo 2^ADDR_W. Example: base 1020, len 8, ADDR_W 10 gives addresses 1020..1023, then 0..3.
- A FIFO bubble (empty_n = 0) stalls the counters. No write is issued and no state is lost.
- words_written increments on each accept, clears on start, and holds its value after DONE until the next start.
- abort in any state:
  - Next cycle: state IDLE; cen and wen all 1; fifo_read 0; counters 0; no done pulse.
  - A word accepted in the abort cycle is dropped (not written).
- reset mid-job has the same effect as abort, and all outputs take their reset values.
- Simultaneous start and abort in IDLE: abort wins and the job does not start.

Test Plan:
- Sequential, NUM_BANK 8, len 4, banks 8, base 0, FIFO never empty, data 0..31 -> bank b receives words 4b..4b+3 at addr 0..3; each write appears 1 cycle after its accept; done pulses in cycle 34 after start; words_written = 32.
- Broadcast, len 3, banks 5, data A,B,C -> banks 0..4 each write A,B,C at addr 0..2 in the same cycles; cen[7:5] = 1 throughout; words_written = 3.
- Wrap and bubbles: sequential, base 1022, len 4, banks 2, empty_n toggling 1,0 -> addresses 1022,1023,0,1 in each bank; no write during bubble cycles; no words lost.
- No-op: start with len 0, then start with banks 0 -> DONE one cycle after start in each case; fifo_read never asserts; cen stays all 1.
- Abort mid-bank: sequential, len 8, abort on the 11th accept -> exactly 10 writes observed; state IDLE next cycle; no done; a new start then completes normally; cfg_bank_num 12 with NUM_BANK 8 clamps to 8 banks.
